// File: rtl/strobe_seq.sv
// Counter-driven strobe sequencer: STROB1, optional STROB2, then GOT, with a
// one-cycle DONE pulse. Every width and gap is an exact clock count.
module strobe_seq #(
    parameter int unsigned S1_TICKS  = 3,
    parameter int unsigned S2_TICKS  = 3,
    parameter int unsigned GAP_TICKS = 1,
    parameter int unsigned GOT_TICKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start_,
    input  logic en,
    input  logic long,
    input  logic hold,
    output logic strob1,
    output logic strob2,
    output logic got,
    output logic busy,
    output logic done
);

    localparam int unsigned MAX_STROBE = (S1_TICKS > S2_TICKS) ? S1_TICKS : S2_TICKS;
    localparam int unsigned MAX_OTHER  = (GAP_TICKS > GOT_TICKS) ? GAP_TICKS : GOT_TICKS;
    localparam int unsigned MAX_TICKS  = (MAX_STROBE > MAX_OTHER) ? MAX_STROBE : MAX_OTHER;
    localparam int unsigned CW         = (MAX_TICKS < 2) ? 1 : $clog2(MAX_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        GAP1 = 3'd2,
        S2   = 3'd3,
        GAP2 = 3'd4,
        GOT  = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          long_r;
    logic          trig_d;
    logic          trig;
    logic          trig_edge;
    logic          cnt_zero;

    assign trig      = ~start_ & en;
    assign trig_edge = trig & ~trig_d;
    assign cnt_zero  = (cnt == '0);

    // Outputs are registered alongside the state so each strobe mirrors its state exactly.
    always_ff @(posedge clk) begin
        // trig_d tracks trig even in reset, so a level held across release cannot start a sequence.
        trig_d <= trig;
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            long_r <= 1'b0;
            strob1 <= 1'b0;
            strob2 <= 1'b0;
            got    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_edge) begin
                        state  <= S1;
                        cnt    <= CW'(S1_TICKS - 1);
                        long_r <= long;
                        strob1 <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                S1: begin
                    if (cnt_zero) begin
                        state  <= GAP1;
                        cnt    <= CW'(GAP_TICKS - 1);
                        strob1 <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                GAP1: begin
                    if (cnt_zero) begin
                        if (long_r) begin
                            state  <= S2;
                            cnt    <= CW'(S2_TICKS - 1);
                            strob2 <= 1'b1;
                        end else begin
                            state <= GOT;
                            cnt   <= CW'(GOT_TICKS - 1);
                            got   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S2: begin
                    if (cnt_zero) begin
                        state  <= GAP2;
                        cnt    <= CW'(GAP_TICKS - 1);
                        strob2 <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                GAP2: begin
                    if (cnt_zero) begin
                        state <= GOT;
                        cnt   <= CW'(GOT_TICKS - 1);
                        got   <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                GOT: begin
                    // Once the minimum width has elapsed, hold keeps GOT asserted with cnt parked at 0.
                    if (cnt_zero) begin
                        if (!hold) begin
                            state <= IDLE;
                            got   <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    strob1 <= 1'b0;
                    strob2 <= 1'b0;
                    got    <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_strobe_seq.sv
// Directed bench for strobe_seq: default-parameter instance plus an all-ones
// parameter instance, checked cycle by cycle against hand-derived masks.
module tb_strobe_seq;

    logic clk = 1'b0;
    logic reset;
    logic start_;
    logic en;
    logic long;
    logic hold;

    logic a_s1, a_s2, a_got, a_busy, a_done;
    logic b_s1, b_s2, b_got, b_busy, b_done;

    int tests = 0;
    int fails = 0;

    string nm [5] = '{"strob1", "strob2", "got", "busy", "done"};

    always #5 clk = ~clk;

    strobe_seq dut_a (
        .clk    (clk),
        .reset  (reset),
        .start_ (start_),
        .en     (en),
        .long   (long),
        .hold   (hold),
        .strob1 (a_s1),
        .strob2 (a_s2),
        .got    (a_got),
        .busy   (a_busy),
        .done   (a_done)
    );

    strobe_seq #(
        .S1_TICKS  (1),
        .S2_TICKS  (1),
        .GAP_TICKS (1),
        .GOT_TICKS (1)
    ) dut_b (
        .clk    (clk),
        .reset  (reset),
        .start_ (start_),
        .en     (en),
        .long   (long),
        .hold   (hold),
        .strob1 (b_s1),
        .strob2 (b_s2),
        .got    (b_got),
        .busy   (b_busy),
        .done   (b_done)
    );

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Trigger is sampled at edge 0; cycle c is the interval after edge c.
    // Mask bit c of tm/lm/hm/rm is the input level during cycle c.
    task automatic run(input logic l0, input logic [31:0] tm, input logic [31:0] lm,
                       input logic [31:0] hm, input logic [31:0] rm,
                       output logic [4:0][31:0] a, output logic [4:0][31:0] b,
                       output int oh);
        oh = 0;
        a  = '0;
        b  = '0;
        start_ = 1'b0;
        en     = 1'b1;
        long   = l0;
        hold   = 1'b0;
        reset  = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            #1;
            a[0][c] = a_s1; a[1][c] = a_s2; a[2][c] = a_got; a[3][c] = a_busy; a[4][c] = a_done;
            b[0][c] = b_s1; b[1][c] = b_s2; b[2][c] = b_got; b[3][c] = b_busy; b[4][c] = b_done;
            if ((32'(a_s1) + 32'(a_s2) + 32'(a_got)) > 32'd1) oh++;
            if ((32'(b_s1) + 32'(b_s2) + 32'(b_got)) > 32'd1) oh++;
            start_ = ~tm[c];
            long   = lm[c];
            hold   = hm[c];
            reset  = rm[c];
        end
        start_ = 1'b1;
        long   = 1'b0;
        hold   = 1'b0;
        reset  = 1'b0;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start_ = 1'b0;
        en     = 1'b1;
        long   = 1'b0;
        hold   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (a_s1 !== 1'b0) begin fails++; $display("FAIL reset strob1 got %b expected 0", a_s1); end
        tests++; if (a_s2 !== 1'b0) begin fails++; $display("FAIL reset strob2 got %b expected 0", a_s2); end
        tests++; if (a_got !== 1'b0) begin fails++; $display("FAIL reset got got %b expected 0", a_got); end
        tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL reset busy got %b expected 0", a_busy); end
        tests++; if (a_done !== 1'b0) begin fails++; $display("FAIL reset done got %b expected 0", a_done); end
        // Trigger level held high across reset release must not start a sequence.
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            tests++;
            if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_release_trig cycle %0d busy a=%b b=%b expected 0", c, a_busy, b_busy);
            end
        end
        start_ = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [4:0][31:0] a,
                           input logic [4:0][31:0] e, input int oh);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (a[i] !== e[i]) begin
                fails++;
                $display("FAIL %s %s got %h expected %h", tag, nm[i], a[i], e[i]);
            end
        end
        tests++;
        if (oh !== 0) begin
            fails++;
            $display("FAIL %s onehot violations got %0d expected 0", tag, oh);
        end
    endtask

    task automatic test_short();
        logic [4:0][31:0] a, b, e;
        int oh;
        run(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, a, b, oh);
        e[0] = rng(0, 2); e[1] = '0; e[2] = rng(4, 5); e[3] = rng(0, 5); e[4] = rng(6, 6);
        check_a("short", a, e, oh);
        // hold during S1 only must change nothing.
        run(1'b0, 32'h0, 32'h0, rng(0, 3), 32'h0, a, b, oh);
        check_a("short_hold_s1", a, e, oh);
    endtask

    task automatic test_long();
        logic [4:0][31:0] a, b, e;
        int oh;
        run(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, a, b, oh);
        e[0] = rng(0, 2); e[1] = rng(4, 6); e[2] = rng(8, 9); e[3] = rng(0, 9); e[4] = rng(10, 10);
        check_a("long", a, e, oh);
    endtask

    task automatic test_hold();
        logic [4:0][31:0] a, b, e;
        int oh;
        run(1'b1, 32'h0, 32'h0, rng(0, 2) | rng(9, 11), 32'h0, a, b, oh);
        e[0] = rng(0, 2); e[1] = rng(4, 6); e[2] = rng(8, 12); e[3] = rng(0, 12); e[4] = rng(13, 13);
        check_a("hold", a, e, oh);
    endtask

    task automatic test_retrigger();
        logic [4:0][31:0] a, b, e;
        int oh;
        run(1'b0, rng(0, 0) | rng(2, 9) | rng(11, 23), 32'h0, 32'h0, 32'h0, a, b, oh);
        e[0] = rng(0, 2) | rng(12, 14);
        e[1] = '0;
        e[2] = rng(4, 5) | rng(16, 17);
        e[3] = rng(0, 5) | rng(12, 17);
        e[4] = rng(6, 6) | rng(18, 18);
        check_a("retrigger", a, e, oh);
    endtask

    task automatic test_reset_mid();
        logic [4:0][31:0] a, b, e;
        int oh;
        run(1'b1, rng(0, 9) | rng(11, 23), 32'h0, 32'h0, rng(5, 5), a, b, oh);
        e[0] = rng(0, 2) | rng(12, 14);
        e[1] = rng(4, 5);
        e[2] = rng(16, 17);
        e[3] = rng(0, 5) | rng(12, 17);
        e[4] = rng(18, 18);
        check_a("reset_mid", a, e, oh);
    endtask

    task automatic test_sweep();
        logic [4:0][31:0] a, b, e;
        int oh;
        run(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, a, b, oh);
        e[0] = rng(0, 0); e[1] = rng(2, 2); e[2] = rng(4, 4); e[3] = rng(0, 4); e[4] = rng(5, 5);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (b[i] !== e[i]) begin
                fails++;
                $display("FAIL sweep %s got %h expected %h", nm[i], b[i], e[i]);
            end
        end
        tests++;
        if (oh !== 0) begin
            fails++;
            $display("FAIL sweep onehot violations got %0d expected 0", oh);
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_hold();
        test_retrigger();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
